// File: rtl/inst_queue.sv
// inst_queue: circular FIFO of fetched {instruction, pc} pairs feeding the
// combinational decoder. The head entry is presented with decoder_en_out and
// popped on the same edge; the queue holds under stall and empties on flush.
module inst_queue #(
  parameter int DEPTH_LOG = 4,
  parameter int INST_W    = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_flush_in,
  input  logic              fetcher_en_in,
  input  logic [INST_W-1:0] fetcher_inst_in,
  input  logic [ADDR_W-1:0] fetcher_pc_in,
  output logic              fetcher_full_out,
  input  logic              stall_in,
  output logic              decoder_en_out,
  output logic [INST_W-1:0] decoder_inst_out,
  output logic [ADDR_W-1:0] decoder_pc_out
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_COUNT = {1'b1, {DEPTH_LOG{1'b0}}};

  logic [INST_W-1:0]    inst_mem [DEPTH];
  logic [ADDR_W-1:0]    pc_mem   [DEPTH];
  logic [DEPTH_LOG-1:0] head;
  logic [DEPTH_LOG-1:0] tail;
  logic [DEPTH_LOG:0]   count;

  logic not_empty;
  logic full;
  logic push;
  logic pop;

  // Dispatch/accept decisions for the current cycle
  always_comb begin
    not_empty        = (count != '0);
    full             = (count == FULL_COUNT);
    decoder_en_out   = rdy_in & ~rst_in & ~rob_flush_in & ~stall_in & not_empty;
    pop              = decoder_en_out;
    push             = rdy_in & fetcher_en_in & ~rob_flush_in & (~full | pop);
    fetcher_full_out = full;
    decoder_inst_out = not_empty ? inst_mem[head] : '0;
    decoder_pc_out   = not_empty ? pc_mem[head]   : '0;
  end

  // Entry storage; contents are not reset, writes only on accepted pushes
  always_ff @(posedge clk_in) begin
    if (!rst_in && push) begin
      inst_mem[tail] <= fetcher_inst_in;
      pc_mem[tail]   <= fetcher_pc_in;
    end
  end

  // Pointer and occupancy update; reset beats flush, flush beats push/pop
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (rob_flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
